// File: rtl/sram_write_ctrl.sv
// sram_write_ctrl: request FIFO feeding timed async-SRAM write cycles, started only while bus_grant is high.
// Define SRAM_WR_VERIFY_EN to add a readback VERIFY pass with a sticky verify_err flag.
module sram_write_ctrl #(
   parameter int unsigned ADDR_W     = 20,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned PULSE_CYC  = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [DATA_W-1:0]           wr_data,
   input  logic [1:0]                  wr_be,
   input  logic                        bus_grant,
   output logic                        bus_busy,
   output logic [ADDR_W-1:0]           SRAM_ADDR,
   output logic [DATA_W-1:0]           SRAM_DATA_OUT,
   output logic                        SRAM_DATA_OE,
   input  logic [DATA_W-1:0]           SRAM_DATA_IN,
   output logic                        SRAM_WE,
   output logic                        SRAM_OE,
   output logic                        SRAM_UB,
   output logic                        SRAM_LB,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [15:0]                 done_count,
   output logic                        verify_err
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENT_W   = ADDR_W + DATA_W + 2;
   localparam int unsigned HALF    = DATA_W / 2;
   localparam int unsigned MAX_CYC = (SETUP_CYC > PULSE_CYC) ?
                                     ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                                     ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
   localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

   localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(SETUP_CYC - 1);
   localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYC - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_VERIFY
   } state_t;

   state_t             state_q;
   logic [TMR_W-1:0]   tmr_q;
   logic [1:0]         be_q;

   logic [ENT_W-1:0]   fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_d;

   logic               push;
   logic               pop;
   logic               tmr_last;
   logic               word_end;
   logic [ENT_W-1:0]   head;
   logic [ADDR_W-1:0]  head_addr;
   logic [DATA_W-1:0]  head_data;
   logic [1:0]         head_be;

   assign head      = fifo_mem_q[rd_ptr_q];
   assign head_be   = head[1:0];
   assign head_data = head[DATA_W+1:2];
   assign head_addr = head[ENT_W-1:DATA_W+2];

   always_comb begin
      push     = wr_valid && wr_ready;
      tmr_last = 1'b0;
      case (state_q)
         S_SETUP:  tmr_last = (tmr_q == SETUP_LAST);
         S_PULSE:  tmr_last = (tmr_q == PULSE_LAST);
         S_HOLD:   tmr_last = (tmr_q == HOLD_LAST);
         S_VERIFY: tmr_last = (tmr_q == PULSE_LAST);
         default:  tmr_last = 1'b0;
      endcase
`ifdef SRAM_WR_VERIFY_EN
      word_end = (state_q == S_VERIFY) && tmr_last;
`else
      word_end = (state_q == S_HOLD) && tmr_last;
`endif
      // A finishing word hands the bus straight to the next entry, so pop is shared by IDLE and word end.
      pop     = bus_grant && (fifo_count != '0) && ((state_q == S_IDLE) || word_end);
      count_d = fifo_count + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge Clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= {wr_addr, wr_data, wr_be};
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_count <= '0;
         wr_ready   <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         fifo_count <= count_d;
         wr_ready   <= (count_d != CNT_W'(FIFO_DEPTH));
      end
   end

`ifdef SRAM_WR_VERIFY_EN
   logic verify_err_q;
   logic lane_err;

   assign lane_err = (be_q[1] && (SRAM_DATA_IN[DATA_W-1:HALF] != SRAM_DATA_OUT[DATA_W-1:HALF])) ||
                     (be_q[0] && (SRAM_DATA_IN[HALF-1:0] != SRAM_DATA_OUT[HALF-1:0]));
   assign verify_err = verify_err_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         verify_err_q <= 1'b0;
      end else if (word_end && lane_err) begin
         verify_err_q <= 1'b1;
      end
   end
`else
   logic unused_data_in;
   assign unused_data_in = ^SRAM_DATA_IN;
   assign verify_err     = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= S_IDLE;
         tmr_q         <= '0;
         be_q          <= '0;
         bus_busy      <= 1'b0;
         SRAM_ADDR     <= '0;
         SRAM_DATA_OUT <= '0;
         SRAM_DATA_OE  <= 1'b0;
         SRAM_WE       <= 1'b1;
         SRAM_OE       <= 1'b1;
         SRAM_UB       <= 1'b1;
         SRAM_LB       <= 1'b1;
         done_count    <= '0;
      end else begin
         case (state_q)
            S_SETUP: begin
               tmr_q <= tmr_last ? '0 : tmr_q + TMR_W'(1);
               if (tmr_last) begin
                  // A word with no byte lanes enabled runs its timing without a WE strobe.
                  SRAM_WE <= (be_q == 2'b00);
                  state_q <= S_PULSE;
               end
            end
            S_PULSE: begin
               tmr_q <= tmr_last ? '0 : tmr_q + TMR_W'(1);
               if (tmr_last) begin
                  SRAM_WE <= 1'b1;
                  state_q <= S_HOLD;
               end
            end
            S_HOLD: begin
               tmr_q <= tmr_last ? '0 : tmr_q + TMR_W'(1);
`ifdef SRAM_WR_VERIFY_EN
               if (tmr_last) begin
                  state_q      <= S_VERIFY;
                  SRAM_DATA_OE <= 1'b0;
                  SRAM_OE      <= 1'b0;
               end
`endif
            end
`ifdef SRAM_WR_VERIFY_EN
            S_VERIFY: begin
               tmr_q <= tmr_last ? '0 : tmr_q + TMR_W'(1);
            end
`endif
            default: begin
               tmr_q <= '0;
            end
         endcase

         if (word_end) begin
            done_count <= done_count + 16'd1;
         end

         if (pop) begin
            state_q       <= S_SETUP;
            tmr_q         <= '0;
            be_q          <= head_be;
            SRAM_ADDR     <= head_addr;
            SRAM_DATA_OUT <= head_data;
            SRAM_UB       <= ~head_be[1];
            SRAM_LB       <= ~head_be[0];
            SRAM_DATA_OE  <= 1'b1;
            SRAM_OE       <= 1'b1;
            bus_busy      <= 1'b1;
         end else if (word_end) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            SRAM_UB      <= 1'b1;
            SRAM_LB      <= 1'b1;
            SRAM_DATA_OE <= 1'b0;
            SRAM_OE      <= 1'b1;
            bus_busy     <= 1'b0;
         end
      end
   end

endmodule
